// File: rtl/usbf_dma_arb_pkg.sv
// Shared constants for the USB function DMA arbiter: state encodings,
// default burst / timeout values and field widths.
package usbf_dma_arb_pkg;

    localparam int unsigned EP_W  = 4;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] USBF_DARB_IDLE = 2'd0;
    localparam logic [1:0] USBF_DARB_XFER = 2'd1;
    localparam logic [1:0] USBF_DARB_ACK  = 2'd2;
    localparam logic [1:0] USBF_DARB_CHK  = 2'd3;

    localparam int unsigned USBF_DARB_BURST_DEF  = 4;
    localparam int unsigned USBF_DARB_TO_CYC_DEF = 255;

endpackage

// File: rtl/usbf_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping
// modulo NEP, with ptr itself searched last.
module usbf_rr_pick
    import usbf_dma_arb_pkg::*;
#(
    parameter int unsigned NEP = 4
) (
    input  logic [NEP-1:0]  req,
    input  logic [EP_W-1:0] ptr,
    output logic [EP_W-1:0] gnt_idx,
    output logic            any
);

    int unsigned off;
    int unsigned best;

    // Distance from ptr+1 in search order; smallest requesting distance wins
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        best    = NEP;
        off     = 0;
        for (int unsigned j = 0; j < NEP; j++) begin
            off = (j + 16 * NEP - 1 - 32'(ptr)) % NEP;
            if (req[j] && (off < best)) begin
                best    = off;
                gnt_idx = EP_W'(j);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usbf_dma_arb.sv
// DMA request arbiter: round-robin endpoint grants with bounded bursts,
// each word forwarded as an ext_req/ext_ack handshake with optional timeout.
module usbf_dma_arb
    import usbf_dma_arb_pkg::*;
#(
    parameter int unsigned NEP    = 4,
    parameter int unsigned BURST  = USBF_DARB_BURST_DEF,
    parameter int unsigned TO_CYC = USBF_DARB_TO_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NEP-1:0]  dma_req,
    output logic [NEP-1:0]  dma_ack,
    output logic            ext_req,
    output logic [EP_W-1:0] ext_ep,
    output logic            ext_last,
    input  logic            ext_ack,
    output logic            to_err,
    output logic            busy
);

    localparam logic [CNT_W-1:0] BURST_C   = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(BURST - 1);
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_CYC - 1);
    localparam bit               TO_EN     = (TO_CYC != 0);

    logic [1:0]       state_q, state_d;
    logic [EP_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [NEP-1:0]   dma_ack_q, dma_ack_d;
    logic             ext_req_q, ext_req_d;
    logic [EP_W-1:0]  ext_ep_q, ext_ep_d;
    logic             ext_last_q, ext_last_d;
    logic             to_err_q, to_err_d;
    logic             busy_q, busy_d;

    logic [EP_W-1:0]  pick_idx;
    logic             pick_any;
    logic [NEP-1:0]   ack_vec;
    logic             req_g;
    logic             grant;

    usbf_rr_pick #(.NEP(NEP)) u_pick (
        .req     (dma_req),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // ptr always holds the endpoint of the current grant
    always_comb begin
        ack_vec = '0;
        req_g   = 1'b0;
        for (int unsigned j = 0; j < NEP; j++) begin
            if (EP_W'(j) == ptr_q) begin
                ack_vec[j] = 1'b1;
                req_g      = dma_req[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= USBF_DARB_IDLE;
            ptr_q      <= EP_W'(NEP - 1);
            cnt_q      <= '0;
            tmr_q      <= '0;
            dma_ack_q  <= '0;
            ext_req_q  <= 1'b0;
            ext_ep_q   <= '0;
            ext_last_q <= 1'b0;
            to_err_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            dma_ack_q  <= dma_ack_d;
            ext_req_q  <= ext_req_d;
            ext_ep_q   <= ext_ep_d;
            ext_last_q <= ext_last_d;
            to_err_q   <= to_err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        dma_ack_d  = '0;
        ext_req_d  = ext_req_q;
        ext_ep_d   = ext_ep_q;
        ext_last_d = ext_last_q;
        to_err_d   = 1'b0;
        grant      = 1'b0;

        case (state_q)
            USBF_DARB_IDLE: begin
                grant = pick_any;
            end
            USBF_DARB_XFER: begin
                if (ext_ack) begin
                    ext_req_d = 1'b0;
                    dma_ack_d = ack_vec;
                    cnt_d     = cnt_q + CNT_W'(1);
                    state_d   = USBF_DARB_ACK;
                end else if (TO_EN && (tmr_q == TO_LAST_C)) begin
                    ext_req_d = 1'b0;
                    to_err_d  = 1'b1;
                    state_d   = USBF_DARB_IDLE;
                end else if (tmr_q != '1) begin
                    tmr_d = tmr_q + CNT_W'(1);
                end
            end
            USBF_DARB_ACK: begin
                state_d = USBF_DARB_CHK;
            end
            USBF_DARB_CHK: begin
                // dma_req here already reflects the endpoint's post-ack update
                if (req_g && (cnt_q < BURST_C)) begin
                    ext_req_d  = 1'b1;
                    ext_ep_d   = ptr_q;
                    ext_last_d = (cnt_q == LAST_C);
                    tmr_d      = '0;
                    state_d    = USBF_DARB_XFER;
                end else if (pick_any) begin
                    grant = 1'b1;
                end else begin
                    state_d = USBF_DARB_IDLE;
                end
            end
            default: state_d = USBF_DARB_IDLE;
        endcase

        if (grant) begin
            ptr_d      = pick_idx;
            ext_ep_d   = pick_idx;
            ext_req_d  = 1'b1;
            ext_last_d = (LAST_C == CNT_W'(0));
            cnt_d      = '0;
            tmr_d      = '0;
            state_d    = USBF_DARB_XFER;
        end

        busy_d = (state_d != USBF_DARB_IDLE);
    end

    assign dma_ack  = dma_ack_q;
    assign ext_req  = ext_req_q;
    assign ext_ep   = ext_ep_q;
    assign ext_last = ext_last_q;
    assign to_err   = to_err_q;
    assign busy     = busy_q;

endmodule
